// File: rtl/mod113_pkg.sv
// Shared constants and state encoding for the mod-113 residue pipeline stages.
package mod113_pkg;

  localparam int MODULUS   = 113;
  localparam int RW        = 7;
  localparam int NUM_TERMS = 67;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mod113_acc_if.sv
// Term-in / result-out handshake bundle for the mod-113 accumulator.
interface mod113_acc_if #(
  parameter int RW = mod113_pkg::RW
);

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_residue;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_residue;
  logic          out_len_err;
  logic          out_rng_err;

  modport master (
    output in_valid, in_residue, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_len_err, out_rng_err
  );

  modport slave (
    input  in_valid, in_residue, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_len_err, out_rng_err
  );

endinterface

// File: rtl/mod_add_red.sv
// Combinational modular adder: folds an out-of-range term once, then adds with a single conditional subtract.
module mod_add_red #(
  parameter int MODULUS = mod113_pkg::MODULUS,
  parameter int RW      = mod113_pkg::RW
) (
  input  logic [RW-1:0] i_acc,
  input  logic [RW-1:0] i_term,
  output logic [RW-1:0] o_sum,
  output logic          o_rng_err
);
  import mod113_pkg::*;

  logic          w_rng;
  logic [RW-1:0] w_term;
  logic [RW:0]   w_s;

  always_comb begin
    w_rng  = (i_term >= RW'(MODULUS));
    w_term = w_rng ? (i_term - RW'(MODULUS)) : i_term;
    w_s    = {1'b0, i_acc} + {1'b0, w_term};
    o_sum  = (w_s >= (RW+1)'(MODULUS)) ? RW'(w_s - (RW+1)'(MODULUS)) : w_s[RW-1:0];
  end

  assign o_rng_err = w_rng;

endmodule

// File: rtl/mod113_acc.sv
// Frame accumulator: sums one partial residue per transfer mod MODULUS and presents
// the result with length/range error flags until the downstream handshake.
module mod113_acc #(
  parameter int MODULUS   = mod113_pkg::MODULUS,
  parameter int RW        = mod113_pkg::RW,
  parameter int NUM_TERMS = mod113_pkg::NUM_TERMS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  mod113_acc_if.slave bus
);
  import mod113_pkg::*;

  state_e           r_state;
  logic [RW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_len_err;
  logic             r_rng_err;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_xfer;
  logic [RW-1:0]    w_acc_in;
  logic [RW-1:0]    w_sum;
  logic             w_term_rng;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_xfer    = bus.in_valid & r_in_ready;
  // The first term of a frame starts from zero instead of any stale accumulator value.
  assign w_acc_in  = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_nxt = (r_state == IDLE) ? CNT_W'(1)
                   : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);

  mod_add_red #(
    .MODULUS (MODULUS),
    .RW      (RW)
  ) u_mod_add_red (
    .i_acc     (w_acc_in),
    .i_term    (bus.in_residue),
    .o_sum     (w_sum),
    .o_rng_err (w_term_rng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_err   <= 1'b0;
      r_rng_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (clear) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_err   <= 1'b0;
      r_rng_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_xfer) begin
            r_acc     <= w_sum;
            r_cnt     <= w_cnt_nxt;
            r_rng_err <= (r_state == ACC) ? (r_rng_err | w_term_rng) : w_term_rng;
            if (bus.in_last) begin
              r_state     <= HOLD;
              r_len_err   <= (w_cnt_nxt != CNT_W'(NUM_TERMS));
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state   <= ACC;
              r_len_err <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_residue = r_acc;
  assign bus.out_len_err = r_len_err;
  assign bus.out_rng_err = r_rng_err;

endmodule

// File: tb/tb_mod113_acc.sv
// Randomized and directed bench for mod113_acc against a sum-then-reduce frame model.
module tb_mod113_acc;
  import mod113_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  mod113_acc_if #(.RW(RW)) bus ();

  mod113_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  int unsigned ft [0:199];

  // {residue, len_err, rng_err} from the whole frame: fold bad terms, sum, reduce once.
  function automatic logic [8:0] model(input int n);
    int unsigned sum;
    int unsigned t;
    bit rng;
    sum = 0;
    rng = 0;
    for (int i = 0; i < n; i++) begin
      t = ft[i];
      if (t >= MODULUS) begin
        rng = 1;
        t = t - MODULUS;
      end
      sum += t;
    end
    return {7'(sum % MODULUS), (n != NUM_TERMS), rng};
  endfunction

  function automatic int unsigned rand_term();
    if ($urandom_range(0, 15) == 0) return $urandom_range(113, 127);
    return $urandom_range(0, 112);
  endfunction

  task automatic drive_frame(input int n, input bit gaps, input bit mark_last);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_residue = 7'(ft[i]);
      bus.in_last    = mark_last && (i == n - 1);
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        vec++;
        err++;
        $display("FAIL in_ready_timeout term=%0d in_ready=%b required=1", i, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid   = 1'b0;
    bus.in_residue = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== 11'b1_0_0000000_0_0) begin
      err++;
      $display("FAIL reset_outputs got=%b required=%b",
               {bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, 11'b1_0_0000000_0_0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      err++;
      $display("FAIL post_reset_idle got=%b required=10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_directed();
    int n;
    logic [8:0] exp;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin n = 67; for (int i = 0; i < n; i++) ft[i] = 112; exp = {7'd46, 1'b0, 1'b0}; end
        1: begin n = 67; for (int i = 0; i < n; i++) ft[i] = 1;   exp = {7'd67, 1'b0, 1'b0}; end
        2: begin n = 67; for (int i = 0; i < n; i++) ft[i] = 0; ft[0] = 100; ft[1] = 20; exp = {7'd7, 1'b0, 1'b0}; end
        3: begin n = 67; for (int i = 0; i < n; i++) ft[i] = 0; ft[0] = 120; exp = {7'd7, 1'b0, 1'b1}; end
        4: begin n = 5;  for (int i = 0; i < n; i++) ft[i] = 10;  exp = {7'd50, 1'b1, 1'b0}; end
        default: begin n = 1; ft[0] = 50; exp = {7'd50, 1'b1, 1'b0}; end
      endcase
      drive_frame(n, 1'b0, 1'b1);
      vec++;
      if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
        err++;
        $display("FAIL directed_%0d got=%b required=%b", c,
                 {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
      end
      accept_result();
      vec++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        err++;
        $display("FAIL directed_release_%0d got=%b required=01", c, {bus.out_valid, bus.in_ready});
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [8:0] exp;
    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 1) == 1) ? NUM_TERMS : $urandom_range(1, 90);
      for (int i = 0; i < n; i++) ft[i] = rand_term();
      exp = model(n);
      drive_frame(n, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        vec++;
        if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
          err++;
          $display("FAIL random_hold_%0d got=%b required=%b", f,
                   {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
        end
        @(negedge clk);
      end
      vec++;
      if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
        err++;
        $display("FAIL random_frame_%0d n=%0d got=%b required=%b", f, n,
                 {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
      end
      accept_result();
    end
  endtask

  task automatic test_hold_stall();
    logic [8:0] exp;
    for (int i = 0; i < NUM_TERMS; i++) ft[i] = rand_term();
    exp = model(NUM_TERMS);
    drive_frame(NUM_TERMS, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      vec++;
      if ({bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {2'b01, exp}) begin
        err++;
        $display("FAIL hold_stall_%0d got=%b required=%b", k,
                 {bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {2'b01, exp});
      end
      bus.in_valid   = 1'b1;
      bus.in_residue = 7'($urandom_range(0, 127));
      bus.in_last    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    vec++;
    if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
      err++;
      $display("FAIL hold_stall_end got=%b required=%b",
               {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
    end
    accept_result();
    for (int i = 0; i < 5; i++) ft[i] = 10;
    drive_frame(5, 1'b0, 1'b1);
    vec++;
    if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, 7'd50, 1'b1, 1'b0}) begin
      err++;
      $display("FAIL hold_stall_next got=%b required=%b",
               {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, 7'd50, 1'b1, 1'b0});
    end
    accept_result();
  endtask

  task automatic test_clear();
    logic [8:0] exp;
    for (int i = 0; i < 29; i++) ft[i] = 120;
    drive_frame(29, 1'b1, 1'b0);
    bus.in_valid   = 1'b1;
    bus.in_residue = 7'd5;
    bus.in_last    = 1'b0;
    clear          = 1'b1;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_residue, bus.out_rng_err} !== {2'b10, 7'd0, 1'b0}) begin
      err++;
      $display("FAIL clear_mid_frame got=%b required=%b",
               {bus.in_ready, bus.out_valid, bus.out_residue, bus.out_rng_err}, {2'b10, 7'd0, 1'b0});
    end
    for (int i = 0; i < NUM_TERMS; i++) ft[i] = $urandom_range(0, 112);
    exp = model(NUM_TERMS);
    drive_frame(NUM_TERMS, 1'b1, 1'b1);
    vec++;
    if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
      err++;
      $display("FAIL clear_second_frame got=%b required=%b",
               {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
    end
    accept_result();
    for (int i = 0; i < 3; i++) ft[i] = 30;
    drive_frame(3, 1'b0, 1'b1);
    clear         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err} !== {2'b10, 7'd0, 1'b0}) begin
      err++;
      $display("FAIL clear_in_hold got=%b required=%b",
               {bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err}, {2'b10, 7'd0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [8:0] exp;
    bus.out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) ft[i] = rand_term();
      exp = model(n);
      drive_frame(n, 1'b0, 1'b1);
      vec++;
      if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, exp}) begin
        err++;
        $display("FAIL back_to_back_%0d got=%b required=%b", f,
                 {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, exp});
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0) begin
      err++;
      $display("FAIL back_to_back_drain got=%b required=0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 30; i++) ft[i] = 112;
    drive_frame(30, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== 11'b1_0_0000000_0_0) begin
      err++;
      $display("FAIL async_reset got=%b required=%b",
               {bus.in_ready, bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, 11'b1_0_0000000_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (bus.out_valid !== 1'b0) begin
        err++;
        $display("FAIL async_reset_no_output_%0d got=%b required=0", k, bus.out_valid);
      end
    end
    for (int i = 0; i < NUM_TERMS; i++) ft[i] = 112;
    drive_frame(NUM_TERMS, 1'b0, 1'b1);
    vec++;
    if ({bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err} !== {1'b1, 7'd46, 1'b0, 1'b0}) begin
      err++;
      $display("FAIL async_reset_recover got=%b required=%b",
               {bus.out_valid, bus.out_residue, bus.out_len_err, bus.out_rng_err}, {1'b1, 7'd46, 1'b0, 1'b0});
    end
    accept_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_stall();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/mod113_acc.md
MOD113_ACC -- requirements
Module: mod113_acc

Interface
REQ-001 Parameter MODULUS, default 113: modulus of all residues.
REQ-002 Parameter RW, default 7: residue width in bits.
REQ-003 Parameter NUM_TERMS, default 67: LUT terms per frame, one per 6-bit slice of the 400-bit operand.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port clear, input, 1: synchronous abort of the current frame.
REQ-007 Port in_valid, input, 1: in_residue and in_last are valid.
REQ-008 Port in_ready, output, 1: block accepts a term this cycle.
REQ-009 Port in_residue, input, RW: one partial residue from an upstream slice LUT (X_0..X_66).
REQ-010 Port in_last, input, 1: marks the final term of a frame.
REQ-011 Port out_valid, output, 1: result is held and valid.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port out_residue, output, RW: frame sum mod MODULUS, always in 0..MODULUS-1.
REQ-014 Port out_len_err, output, 1: frame term count differed from NUM_TERMS.
REQ-015 Port out_rng_err, output, 1: at least one input term was >= MODULUS.

Function
REQ-016 A transfer occurs on any cycle with in_valid and in_ready both high.
REQ-017 A state machine SHALL use three states: IDLE (no frame open), ACC (frame open), HOLD (result presented).
- IDLE to ACC on a transfer with in_last=0.
- IDLE or ACC to HOLD on a transfer with in_last=1.
- HOLD to IDLE when out_valid and out_ready are both high.
REQ-018 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; in_ready SHALL NOT depend combinationally on out_ready.
REQ-019 A term >= MODULUS SHALL first be reduced by one subtraction of MODULUS, and that frame's range-error flag SHALL be set.
REQ-020 On each transfer, the accumulator SHALL take s = acc + term' as an RW+1-bit sum, then s - MODULUS if s >= MODULUS, else s.
REQ-021 The first transfer of a frame (in IDLE) SHALL load the accumulator with 0 + term'.
REQ-022 A term counter SHALL count transfers in the frame, saturate at 127, and be evaluated when in_last is seen: out_len_err = (count != NUM_TERMS).
REQ-023 Latency: out_valid SHALL rise in the cycle after the in_last transfer, with out_residue already including the last term.
REQ-024 In HOLD, out_residue, out_len_err and out_rng_err SHALL stay stable until the handshake completes.
REQ-025 out_valid SHALL be 1 only in HOLD.
REQ-026 A single-term frame (in_last on the first term) SHALL be legal and SHALL set out_len_err, since 1 != NUM_TERMS.
REQ-027 clear SHALL force IDLE and zero the accumulator, counter and flags on the next edge, from any state, and SHALL discard any coincident transfer or output handshake.
REQ-028 in_valid while in HOLD SHALL be ignored, with no state change.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE.
REQ-030 While rst_n=0, out_valid=0, in_ready=1, out_residue=0, out_len_err=0 and out_rng_err=0.
REQ-031 While rst_n=0, the accumulator and counter SHALL be 0.
REQ-032 Reset asserted mid-frame or in HOLD SHALL drop the frame with no output.

Structure
REQ-033 MODULUS, RW, NUM_TERMS and the state enum SHALL live in shared package mod113_pkg, reused by the other mod_113 stages.
REQ-034 The modular adder (REQ-019, REQ-020) SHALL be a combinational sub-module mod_add_red.
REQ-035 The block SHALL contain no other sub-modules.

Verification
REQ-036 67 terms of 112, in_last on term 67 -> out_residue=46, out_len_err=0, out_rng_err=0, one cycle after the last transfer.
REQ-037 67 terms of 1 -> out_residue=67; terms 100, 20, then 65 zeros -> out_residue=7 (wrap case).
REQ-038 Term 120 then 66 zeros -> out_residue=7, out_rng_err=1.
REQ-039 Frame of 5 terms of 10, in_last on term 5 -> out_residue=50, out_len_err=1.
REQ-040 out_ready held low 10 cycles in HOLD with in_valid=1 -> outputs stable and in_ready=0 throughout, and no term consumed.
REQ-041 clear on term 30, then a full 67-term frame -> result reflects only the second frame.
REQ-042 rst_n pulsed low in ACC -> all outputs at reset values immediately (asynchronously), with no out_valid afterwards.
